// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM states, owner codes and DMType encodings shared by the arbiter slice
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;
  localparam logic [2:0] FETCH_TYPE = DM_WORD;
endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating count of data grants taken while a fetch was waiting
module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt;
  assign at_max = cnt == W'(MAX);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and MEM stage accesses onto one fixed-latency memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_type,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [2:0]        m_type,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  arb_state_e state, state_nx;
  owner_e     owner;
  logic [3:0] lat;
  logic       we_q, at_max, grant_if, grant_d, start, last_wait;
  // Data wins by default; a saturated starvation count hands the slot to fetch
  assign grant_if  = if_req & (~d_req | at_max);
  assign grant_d   = d_req & ~grant_if;
  assign start     = state == S_IDLE && (if_req || d_req);
  assign last_wait = state == S_WAIT && lat == 4'd1;
  assign m_en      = state == S_ISSUE;
  assign m_we      = m_en & we_q;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;
  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (start & grant_d & if_req),
    .clr    (start & grant_if),
    .at_max (at_max)
  );
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = start ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  state_nx = last_wait ? S_RESP : S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (reset) begin
      owner    <= OWN_IF;
      we_q     <= 1'b0;
      lat      <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_type   <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
    end else begin
      if (start) begin
        owner  <= grant_if ? OWN_IF : OWN_D;
        we_q   <= grant_d & d_we;
        m_addr <= grant_if ? if_addr : d_addr;
        m_type <= grant_if ? FETCH_TYPE : d_type;
        if (grant_d) m_wdata <= d_wdata;
      end
      if (state == S_ISSUE) lat <= 4'(MEM_LAT);
      else if (state == S_WAIT) lat <= lat - 4'd1;
      // Responses are registered here so RESP carries the word captured at the end of WAIT
      if_valid <= last_wait && owner == OWN_IF;
      d_valid  <= last_wait && owner == OWN_D;
      if (last_wait && owner == OWN_IF) if_rdata <= m_rdata;
      if (last_wait && owner == OWN_D) d_rdata <= we_q ? '0 : m_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation and reset abort
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic        if_req = 0, d_req = 0, d_we = 0, if_req3 = 0, d_req3 = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [2:0]  d_type = 0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        if_valid, d_valid, m_en, m_we, stall_if, stall_mem;
  logic [2:0]  m_type;
  logic [31:0] if_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
  logic        if_valid3, d_valid3, m_en3, m_we3, stall_if3, stall_mem3;
  logic [2:0]  m_type3;
  logic [31:0] p1 = 0;
  logic [31:0] p3 [3] = '{0, 0, 0};
  int n_chk = 0, n_fail = 0;

  mem_port_arbiter #(.MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_type(m_type),
    .m_rdata(m_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );
  mem_port_arbiter #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_rdata(d_rdata3), .d_valid(d_valid3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_type(m_type3),
    .m_rdata(m_rdata3), .stall_if(stall_if3), .stall_mem(stall_mem3)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h005000D3;
  endfunction
  // Memory models: data appears MEM_LAT cycles after the m_en cycle, junk otherwise
  always @(posedge clk) p1 <= m_en ? word(m_addr) : 32'hBAD0BAD0;
  always @(posedge clk) begin
    p3[0] <= m_en3 ? word(m_addr3) : 32'hBAD0BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m_rdata  = p1;
  assign m_rdata3 = p3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    reset = 1; if_req = 0; d_req = 0; if_req3 = 0; d_req3 = 0; d_we = 0;
    cyc(2);
    reset = 0;
  endtask

  initial begin
    int g, bound;
    logic both, seen;
    do_reset();
    #1;
    check("rst_m_en", m_en, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_stall_if", stall_if, 0);
    // fetch only
    if_addr = 32'h40; if_req = 1; #1;
    check("f_stall_t", stall_if, 1);
    cyc();
    check("f_m_en", m_en, 1);
    check("f_m_addr", m_addr, 32'h40);
    check("f_m_we", m_we, 0);
    check("f_m_type", m_type, 0);
    cyc();
    check("f_m_en_wait", m_en, 0);
    check("f_stall_t2", stall_if, 1);
    check("f_valid_early", if_valid, 0);
    cyc();
    check("f_if_valid", if_valid, 1);
    check("f_if_rdata", if_rdata, 32'h00500093);
    check("f_d_valid", d_valid, 0);
    check("f_stall_t3", stall_if, 0);
    if_req = 0;
    cyc();
    check("f_valid_pulse", if_valid, 0);
    // collision: data first, then fetch
    if_addr = 32'h40; if_req = 1; d_addr = 32'h100; d_we = 0; d_type = DM_WORD; d_req = 1;
    cyc();
    check("c_m_addr_d", m_addr, 32'h100);
    cyc(2);
    check("c_d_valid", d_valid, 1);
    check("c_d_rdata", d_rdata, 32'h005001D3);
    check("c_if_valid_lo", if_valid, 0);
    d_req = 0;
    cyc(2);
    check("c_m_en_f", m_en, 1);
    check("c_m_addr_f", m_addr, 32'h40);
    check("c_stall_mem", stall_mem, 0);
    check("c_stall_if", stall_if, 1);
    cyc(2);
    check("c_if_valid", if_valid, 1);
    check("c_if_rdata", if_rdata, 32'h00500093);
    check("c_d_valid_lo", d_valid, 0);
    if_req = 0;
    cyc();
    // store
    d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_type = DM_WORD; d_req = 1; #1;
    check("s_stall_mem", stall_mem, 1);
    cyc();
    check("s_m_en", m_en, 1);
    check("s_m_we", m_we, 1);
    check("s_m_addr", m_addr, 32'h200);
    check("s_m_wdata", m_wdata, 32'hDEADBEEF);
    check("s_m_type", m_type, DM_WORD);
    cyc();
    check("s_m_we_off", m_we, 0);
    cyc();
    check("s_d_valid", d_valid, 1);
    check("s_d_rdata", d_rdata, 0);
    d_req = 0; d_we = 0;
    cyc();
    check("s_m_wdata_hold", m_wdata, 32'hDEADBEEF);
    // MEM_LAT = 3 load
    d_addr = 32'h100; d_type = DM_BYTE; d_req3 = 1;
    cyc();
    check("l3_m_en", m_en3, 1);
    check("l3_m_type", m_type3, DM_BYTE);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      seen |= m_en3 | d_valid3;
    end
    check("l3_quiet_wait", seen, 0);
    cyc();
    check("l3_d_valid", d_valid3, 1);
    check("l3_d_rdata", d_rdata3, 32'h005001D3);
    d_req3 = 0;
    cyc();
    // starvation
    do_reset();
    if_addr = 32'h40; if_req = 1; d_addr = 32'h300; d_we = 0; d_req = 1;
    g = 0; bound = 0; both = 0;
    while (g < 10 && bound < 200) begin
      cyc();
      bound++;
      both |= if_valid & d_valid;
      if (m_en) begin
        check($sformatf("st_grant%0d", g), m_addr, (g == 4 || g == 9) ? 32'h40 : 32'h300);
        g++;
      end
    end
    check("st_grants", g, 10);
    check("st_excl", both, 0);
    if_req = 0; d_req = 0;
    cyc(4);
    // reset during WAIT
    do_reset();
    if_addr = 32'h80; if_req = 1;
    cyc(2);
    reset = 1; if_req = 0;
    cyc();
    check("r_m_en", m_en, 0);
    check("r_m_addr", m_addr, 0);
    check("r_if_valid", if_valid, 0);
    check("r_if_rdata", if_rdata, 0);
    reset = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      seen |= if_valid | d_valid | m_en;
    end
    check("r_no_pulse", seen, 0);
    if_addr = 32'h40; if_req = 1;
    cyc();
    check("r_fresh_m_en", m_en, 1);
    cyc(2);
    check("r_fresh_valid", if_valid, 1);
    check("r_fresh_rdata", if_rdata, 32'h00500093);
    if_req = 0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
